// File: rtl/syscall_unit.sv
// Syscall execution unit: decodes v0, queues print requests for a valid/ready consumer, holds sticky halt/exit code.
// Prints are visible on out_valid one cycle after acceptance; a print into a full queue stalls the CPU (no same-cycle pop bypass).

module syscall_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_fire;
  logic          pop_fire;

  assign pop_vld   = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_fire  = pop_vld & pop_rdy;
  assign push_fire = push_vld & ~full;
  assign pop_dat   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_fire) - (AW+1)'(pop_fire);
    end
  end
endmodule

module syscall_unit #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CODE_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              stall,
  output logic              halt,
  output logic [DATA_W-1:0] exit_code,
  output logic              bad_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_kind,
  output logic [15:0]       sys_count
);
  typedef struct packed {
    logic              kind;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [CODE_W-1:0] C_PRINT_INT  = CODE_W'(1);
  localparam logic [CODE_W-1:0] C_EXIT       = CODE_W'(10);
  localparam logic [CODE_W-1:0] C_PRINT_CHAR = CODE_W'(11);
  localparam logic [CODE_W-1:0] C_EXIT2      = CODE_W'(17);

  logic   active;
  logic   is_print;
  logic   accept;
  logic   push_vld;
  logic   full;
  entry_t push_dat;
  entry_t head_dat;

  assign active   = enable & ~halt;
  assign is_print = (v0 == C_PRINT_INT) | (v0 == C_PRINT_CHAR);
  assign stall    = active & is_print & full;
  assign accept   = active & ~stall;
  assign push_vld = accept & is_print;

  always_comb begin
    push_dat.kind = (v0 == C_PRINT_CHAR);
    push_dat.data = (v0 == C_PRINT_CHAR) ? DATA_W'(a0[7:0]) : a0;
  end

  syscall_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (out_ready),
    .pop_vld  (out_valid),
    .pop_dat  (head_dat),
    .full     (full)
  );

  assign out_data = head_dat.data;
  assign out_kind = head_dat.kind;

  always_ff @(posedge clk) begin
    if (reset) begin
      halt      <= 1'b0;
      exit_code <= '0;
      bad_code  <= 1'b0;
      sys_count <= '0;
    end else if (accept) begin
      sys_count <= sys_count + 16'd1;
      case (v0)
        C_PRINT_INT, C_PRINT_CHAR: ;
        C_EXIT: begin
          halt      <= 1'b1;
          exit_code <= '0;
        end
        C_EXIT2: begin
          halt      <= 1'b1;
          exit_code <= a0;
        end
        default: bad_code <= 1'b1;
      endcase
    end
  end
endmodule
